// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode constants,
// FSM state encoding and trap cause codes.
package instr_sequencer_pkg;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0000011;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_TIMEOUT = 2'b01,
      CAUSE_ILLEGAL = 2'b10
   } trap_cause_t;

   function automatic logic is_legal_opcode(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_I);
   endfunction

endpackage

// File: rtl/instr_sequencer_seq_cycle_timer.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
module seq_cycle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && !zero)
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH -> DECODE -> EXECUTE -> WRITEBACK sequencer with
// req/ack instruction fetch, fetch timeout and illegal-opcode traps.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                EXEC_CYCLES = 1,
   parameter int                TIMEOUT     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              trap_clr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr_word,
   input  logic              dec_reg_write,
   output logic              alu_hold,
   output logic              rf_we,
   output logic              retire,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       instr_count,
   output logic              trap,
   output logic [1:0]        trap_cause
);

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int EX_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   state_t      state, next_state;
   trap_cause_t cause;
   logic        legal;
   logic        fetch_load, fetch_zero;
   logic        exec_load, exec_zero;

   assign legal     = is_legal_opcode(instr_word[6:0]);
   assign imem_addr = pc;

   // Timers reload on state entry, so each visit starts a fresh count.
   assign fetch_load = (next_state == S_FETCH) && (state != S_FETCH);
   assign exec_load  = (next_state == S_EXECUTE) && (state != S_EXECUTE);

   seq_cycle_timer #(.W(TO_W)) fetch_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (fetch_load),
      .load_val (TO_W'(TIMEOUT - 1)),
      .en       (state == S_FETCH),
      .zero     (fetch_zero)
   );

   seq_cycle_timer #(.W(EX_W)) exec_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (exec_load),
      .load_val (EX_W'(EXEC_CYCLES - 1)),
      .en       (state == S_EXECUTE),
      .zero     (exec_zero)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   // NOTE: each combinational output gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (run) next_state = S_FETCH;
         S_FETCH: begin
            if (imem_ack)
               next_state = S_DECODE;
            else if (fetch_zero)
               next_state = S_TRAP;
         end
         S_DECODE:    next_state = legal ? S_EXECUTE : S_TRAP;
         S_EXECUTE:   if (exec_zero) next_state = S_WRITEBACK;
         S_WRITEBACK: next_state = run ? S_FETCH : S_IDLE;
         S_TRAP:      if (trap_clr) next_state = S_IDLE;
         default:     next_state = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      alu_hold = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
      trap     = 1'b0;
      case (state)
         S_FETCH:     imem_req = 1'b1;
         S_EXECUTE:   alu_hold = 1'b1;
         S_WRITEBACK: begin
            rf_we  = dec_reg_write;
            retire = 1'b1;
         end
         S_TRAP:      trap = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr_word  <= '0;
         instr_count <= '0;
         cause       <= CAUSE_NONE;
      end else begin
         if (state == S_FETCH && imem_ack)
            instr_word <= imem_rdata;
         if (state == S_WRITEBACK) begin
            pc          <= pc + ADDR_W'(4);
            instr_count <= instr_count + 32'd1;
         end
         if (state == S_FETCH && !imem_ack && fetch_zero)
            cause <= CAUSE_TIMEOUT;
         else if (state == S_DECODE && !legal)
            cause <= CAUSE_ILLEGAL;
         else if (state == S_TRAP && trap_clr)
            cause <= CAUSE_NONE;
      end
   end

   assign trap_cause = cause;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer: default instance plus a
// wrap/long-execute instance (RESET_PC=FFFF_FFFC, EXEC_CYCLES=3, TIMEOUT=4).
module tb_instr_sequencer;

   localparam logic [31:0] ADD = 32'h002081B3;
   localparam logic [31:0] LW  = 32'h00002083;
   localparam logic [31:0] LUI = 32'h00000037;

   logic        clk = 1'b0;
   logic        reset, run, trap_clr, imem_ack, dec_reg_write;
   logic [31:0] imem_rdata;
   logic        imem_req, alu_hold, rf_we, retire, trap;
   logic [31:0] imem_addr, instr_word, pc, instr_count;
   logic [1:0]  trap_cause;

   logic        w_run, w_trap_clr, w_ack, w_dec;
   logic [31:0] w_rdata;
   logic        w_req, w_alu_hold, w_rf_we, w_retire, w_trap;
   logic [31:0] w_addr, w_instr_word, w_pc, w_count;
   logic [1:0]  w_cause;

   int compared   = 0;
   int mismatched = 0;
   int retires;

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk (clk), .reset (reset), .run (run), .trap_clr (trap_clr),
      .imem_req (imem_req), .imem_addr (imem_addr), .imem_ack (imem_ack),
      .imem_rdata (imem_rdata), .instr_word (instr_word),
      .dec_reg_write (dec_reg_write), .alu_hold (alu_hold), .rf_we (rf_we),
      .retire (retire), .pc (pc), .instr_count (instr_count),
      .trap (trap), .trap_cause (trap_cause)
   );

   instr_sequencer #(
      .ADDR_W (32), .RESET_PC (32'hFFFF_FFFC), .EXEC_CYCLES (3), .TIMEOUT (4)
   ) dut_wrap (
      .clk (clk), .reset (reset), .run (w_run), .trap_clr (w_trap_clr),
      .imem_req (w_req), .imem_addr (w_addr), .imem_ack (w_ack),
      .imem_rdata (w_rdata), .instr_word (w_instr_word),
      .dec_reg_write (w_dec), .alu_hold (w_alu_hold), .rf_we (w_rf_we),
      .retire (w_retire), .pc (w_pc), .instr_count (w_count),
      .trap (w_trap), .trap_cause (w_cause)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; trap_clr = 1'b0; imem_ack = 1'b0;
      imem_rdata = '0; dec_reg_write = 1'b0;
      w_run = 1'b0; w_trap_clr = 1'b0; w_ack = 1'b0; w_rdata = '0; w_dec = 1'b0;
      step(); step();

      // Reset state
      check("rst_req", imem_req, 0);
      check("rst_pc", pc, 0);
      check("rst_ir", instr_word, 0);
      check("rst_count", instr_count, 0);
      check("rst_trap", trap, 0);
      check("rst_cause", trap_cause, 0);
      check("rst_retire", retire, 0);
      check("rst_rf_we", rf_we, 0);
      check("rst_hold", alu_hold, 0);
      check("rst_w_pc", w_pc, 32'hFFFF_FFFC);

      // 1: zero-wait ADD, retire at cycle 4
      reset = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = ADD; dec_reg_write = 1'b1;
      step();
      check("t1_req", imem_req, 1);
      check("t1_addr", imem_addr, 0);
      step();
      imem_ack = 1'b0;
      check("t1_ir", instr_word, ADD);
      check("t1_dec_req", imem_req, 0);
      step();
      check("t1_hold", alu_hold, 1);
      check("t1_early_retire", retire, 0);
      run = 1'b0;
      step();
      check("t1_retire", retire, 1);
      check("t1_rf_we", rf_we, 1);
      check("t1_wb_hold", alu_hold, 0);
      step();
      check("t1_pc", pc, 32'h4);
      check("t1_count", instr_count, 1);
      check("t1_idle_retire", retire, 0);
      check("t1_idle_req", imem_req, 0);

      // 2: ack delayed 3 cycles, ack outside FETCH ignored, rf_we gated
      run = 1'b1; imem_ack = 1'b0; dec_reg_write = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("t2_req", imem_req, 1);
         check("t2_addr", imem_addr, 32'h4);
      end
      imem_ack = 1'b1; imem_rdata = LW;
      step();
      check("t2_dec_req", imem_req, 0);
      imem_rdata = 32'hDEADBEEF;
      step();
      imem_ack = 1'b0;
      check("t2_ir_hold", instr_word, LW);
      check("t2_hold", alu_hold, 1);
      step();
      check("t2_retire", retire, 1);
      check("t2_rf_we", rf_we, 0);
      run = 1'b0;
      step();
      check("t2_pc", pc, 32'h8);
      check("t2_count", instr_count, 2);

      // 3: fetch timeout after 16 cycles
      run = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         check("t3_req", imem_req, 1);
         check("t3_no_trap", trap, 0);
      end
      step();
      check("t3_trap", trap, 1);
      check("t3_cause", trap_cause, 1);
      check("t3_pc", pc, 32'h8);
      check("t3_req_off", imem_req, 0);
      step();
      check("t3_trap_held", trap, 1);
      trap_clr = 1'b1; run = 1'b0;
      step();
      trap_clr = 1'b0;
      check("t3_clr_trap", trap, 0);
      check("t3_clr_cause", trap_cause, 0);
      check("t3_clr_req", imem_req, 0);

      // 4: illegal opcode (LUI)
      run = 1'b1; imem_ack = 1'b1; imem_rdata = LUI; dec_reg_write = 1'b1;
      step();
      step();
      imem_ack = 1'b0;
      check("t4_ir", instr_word, LUI);
      check("t4_dec_rf_we", rf_we, 0);
      step();
      check("t4_trap", trap, 1);
      check("t4_cause", trap_cause, 2);
      check("t4_pc", pc, 32'h8);
      check("t4_count", instr_count, 2);
      check("t4_rf_we", rf_we, 0);
      check("t4_ir_hold", instr_word, LUI);
      run = 1'b0; trap_clr = 1'b1;
      step();
      trap_clr = 1'b0;
      check("t4_clr_trap", trap, 0);
      check("t4_clr_cause", trap_cause, 0);

      // 5: run dropped in EXECUTE, then reset in EXECUTE
      run = 1'b1; imem_ack = 1'b1; imem_rdata = ADD;
      step();
      step();
      imem_ack = 1'b0;
      step();
      check("t5_hold", alu_hold, 1);
      run = 1'b0;
      step();
      check("t5_retire", retire, 1);
      step();
      check("t5_idle_req", imem_req, 0);
      check("t5_pc", pc, 32'hC);
      check("t5_count", instr_count, 3);
      step();
      check("t5_stay_idle", imem_req, 0);
      run = 1'b1; imem_ack = 1'b1;
      step();
      step();
      imem_ack = 1'b0;
      step();
      check("t5_hold2", alu_hold, 1);
      reset = 1'b1; run = 1'b0;
      step();
      check("t5_rst_retire", retire, 0);
      check("t5_rst_hold", alu_hold, 0);
      check("t5_rst_pc", pc, 0);
      check("t5_rst_count", instr_count, 0);
      check("t5_rst_req", imem_req, 0);
      reset = 1'b0;
      step();
      check("t5_idle_after_rst", imem_req, 0);

      // 6a: ten back-to-back instructions
      run = 1'b1; imem_ack = 1'b1; imem_rdata = ADD; dec_reg_write = 1'b1;
      retires = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (retire) retires++;
         if (i == 40) run = 1'b0;
      end
      imem_ack = 1'b0;
      step();
      check("t6_count", instr_count, 10);
      check("t6_pc", pc, 32'h28);
      check("t6_retires", retires, 10);
      check("t6_idle", imem_req, 0);

      // 6b: PC wrap with EXEC_CYCLES=3, then TIMEOUT=4
      w_run = 1'b1; w_ack = 1'b1; w_rdata = ADD; w_dec = 1'b1;
      step();
      check("w_req", w_req, 1);
      check("w_addr", w_addr, 32'hFFFF_FFFC);
      step();
      w_ack = 1'b0;
      step();
      check("w_hold1", w_alu_hold, 1);
      step();
      check("w_hold2", w_alu_hold, 1);
      step();
      check("w_hold3", w_alu_hold, 1);
      check("w_early_retire", w_retire, 0);
      w_run = 1'b0;
      step();
      check("w_retire", w_retire, 1);
      check("w_rf_we", w_rf_we, 1);
      check("w_wb_hold", w_alu_hold, 0);
      step();
      check("w_pc_wrap", w_pc, 0);
      check("w_count", w_count, 1);
      w_run = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("w_to_req", w_req, 1);
      end
      step();
      check("w_to_trap", w_trap, 1);
      check("w_to_cause", w_cause, 1);
      check("w_to_pc", w_pc, 0);
      w_trap_clr = 1'b1; w_run = 1'b0;
      step();
      w_trap_clr = 1'b0;
      check("w_clr_trap", w_trap, 0);
      check("w_clr_cause", w_cause, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
